// File: rtl/riscv_core_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_cla_pipe
// Brief    : Skewed-pipeline carry-lookahead add/sub built from 4-bit groups,
//            valid/ready handshake with global stall and a tag sideband.
//            Optional status flags enabled by RISCV_CORE_CLA_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_core_cla_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_cin,
    input  logic             i_sub,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic [TAG_W-1:0] o_tag
`ifdef RISCV_CORE_CLA_FLAGS_EN
    ,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_ovf
`endif
);

    localparam int NG   = WIDTH / 4;
    localparam int GS   = NG / STAGES;
    localparam int SW   = GS * 4;
    localparam int LAST = STAGES - 1;

    // Returns {carry_out, sum[3:0]} of one 4-bit lookahead group.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    logic             w_adv;

    // Per-stage inputs (from previous stage registers, or the conditioned ports).
    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_s_in   [STAGES];
    logic             w_c_in   [STAGES];
    logic [TAG_W-1:0] w_t_in   [STAGES];
    logic             w_v_in   [STAGES];

    // Per-stage combinational results and register outputs.
    logic [WIDTH-1:0] w_s_nxt  [STAGES];
    logic             w_c_nxt  [STAGES];
    logic [WIDTH-1:0] w_a_q    [STAGES];
    logic [WIDTH-1:0] w_b_q    [STAGES];
    logic [WIDTH-1:0] w_s_q    [STAGES];
    logic             w_c_q    [STAGES];
    logic [TAG_W-1:0] w_t_q    [STAGES];
    logic             w_v_q    [STAGES];

    assign o_valid = w_v_q[LAST];
    assign w_adv   = ~o_valid | i_ready;
    assign o_ready = w_adv;
    assign o_sum   = w_s_q[LAST];
    assign o_cout  = w_c_q[LAST];
    assign o_tag   = w_t_q[LAST];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [WIDTH-1:0] r_s;
        logic             r_c;
        logic [TAG_W-1:0] r_t;
        logic             r_v;
        logic [WIDTH-1:0] w_sum;
        logic             w_cout;

        if (k == 0) begin : g_first
            assign w_a_in[k] = i_op1;
            assign w_b_in[k] = i_op2 ^ {WIDTH{i_sub}};
            assign w_s_in[k] = '0;
            assign w_c_in[k] = i_cin ^ i_sub;
            assign w_t_in[k] = i_tag;
            assign w_v_in[k] = i_valid;
        end else begin : g_chain
            assign w_a_in[k] = w_a_q[k-1];
            assign w_b_in[k] = w_b_q[k-1];
            assign w_s_in[k] = w_s_q[k-1];
            assign w_c_in[k] = w_c_q[k-1];
            assign w_t_in[k] = w_t_q[k-1];
            assign w_v_in[k] = w_v_q[k-1];
        end

        // Ripple group carries through this stage's slice; lower slices pass through.
        always_comb begin
            logic       c;
            logic [4:0] grp;
            c     = w_c_in[k];
            grp   = '0;
            w_sum = w_s_in[k];
            for (int g = 0; g < GS; g++) begin
                grp = cla4(w_a_in[k][k*SW + 4*g +: 4], w_b_in[k][k*SW + 4*g +: 4], c);
                w_sum[k*SW + 4*g +: 4] = grp[3:0];
                c = grp[4];
            end
            w_cout = c;
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_a <= '0;
                r_b <= '0;
                r_s <= '0;
                r_c <= 1'b0;
                r_t <= '0;
                r_v <= 1'b0;
            end else if (w_adv) begin
                r_a <= w_a_in[k];
                r_b <= w_b_in[k];
                r_s <= w_sum;
                r_c <= w_cout;
                r_t <= w_t_in[k];
                r_v <= w_v_in[k];
            end
        end

        assign w_s_nxt[k] = w_sum;
        assign w_c_nxt[k] = w_cout;
        assign w_a_q[k]   = r_a;
        assign w_b_q[k]   = r_b;
        assign w_s_q[k]   = r_s;
        assign w_c_q[k]   = r_c;
        assign w_t_q[k]   = r_t;
        assign w_v_q[k]   = r_v;
    end

    // Already-consumed operand bits are carried for uniformity only.
    logic w_unused_ops;
    always_comb begin
        w_unused_ops = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            w_unused_ops = w_unused_ops ^ (^w_a_q[i]) ^ (^w_b_q[i]);
        end
    end

`ifdef RISCV_CORE_CLA_FLAGS_EN
    logic r_zero;
    logic r_neg;
    logic r_ovf;
    logic w_msb_cin;

    // Carry into the MSB recovered from sum = a ^ b ^ c at that bit.
    assign w_msb_cin = w_a_in[LAST][WIDTH-1] ^ w_b_in[LAST][WIDTH-1] ^ w_s_nxt[LAST][WIDTH-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_adv) begin
            r_zero <= (w_s_nxt[LAST] == '0);
            r_neg  <= w_s_nxt[LAST][WIDTH-1];
            r_ovf  <= w_msb_cin ^ w_c_nxt[LAST];
        end
    end

    assign o_zero = r_zero;
    assign o_neg  = r_neg;
    assign o_ovf  = r_ovf;
`else
    logic w_unused_nxt;
    always_comb begin
        w_unused_nxt = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            w_unused_nxt = w_unused_nxt ^ (^w_s_nxt[i]) ^ w_c_nxt[i];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_core_cla_pipe
// Brief    : Randomized and directed bench for riscv_core_cla_pipe against an
//            arithmetic scoreboard model (flags checked under RISCV_CORE_CLA_FLAGS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_core_cla_pipe;

    localparam int W      = 64;
    localparam int STAGES = 4;
    localparam int TAG_W  = 4;

    logic             clk;
    logic             rst;
    logic             i_valid;
    logic             o_ready;
    logic [W-1:0]     i_op1;
    logic [W-1:0]     i_op2;
    logic             i_cin;
    logic             i_sub;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [W-1:0]     o_sum;
    logic             o_cout;
    logic [TAG_W-1:0] o_tag;
`ifdef RISCV_CORE_CLA_FLAGS_EN
    logic             o_zero;
    logic             o_neg;
    logic             o_ovf;
`endif

    riscv_core_cla_pipe #(.WIDTH(W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op1   (i_op1),
        .i_op2   (i_op2),
        .i_cin   (i_cin),
        .i_sub   (i_sub),
        .i_tag   (i_tag),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout),
        .o_tag   (o_tag)
`ifdef RISCV_CORE_CLA_FLAGS_EN
        ,
        .o_zero  (o_zero),
        .o_neg   (o_neg),
        .o_ovf   (o_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     sum;
        logic             cout;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             neg;
        logic             ovf;
        int               acc_cyc;
        int               acc_stalls;
    } exp_t;

    exp_t q[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   stalls   = 0;
    int   consumed = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain two's-complement arithmetic on WIDTH+1 bits.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub,
                                   input logic [TAG_W-1:0] tag, input int cy, input int st);
        exp_t         e;
        logic [W:0]   r;
        logic [W-1:0] be;
        be = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + (W+1)'(cin ^ sub);
        e.sum        = r[W-1:0];
        e.cout       = r[W];
        e.tag        = tag;
        e.zero       = (r[W-1:0] == '0);
        e.neg        = r[W-1];
        e.ovf        = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
        e.acc_cyc    = cy;
        e.acc_stalls = st;
        return e;
    endfunction

    // Scoreboard monitor: inputs and outputs are settled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
        end else begin
            check("ready_rule", o_ready, !o_valid || i_ready);
            if (o_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", o_valid, 1'b0);
                end else begin
                    check("sum", o_sum, q[0].sum);
                    check("cout", o_cout, q[0].cout);
                    check("tag", o_tag, q[0].tag);
`ifdef RISCV_CORE_CLA_FLAGS_EN
                    check("zero", o_zero, q[0].zero);
                    check("neg", o_neg, q[0].neg);
                    check("ovf", o_ovf, q[0].ovf);
`endif
                    if (i_ready) begin
                        if (q[0].acc_stalls == stalls)
                            check("latency", W'(cyc - q[0].acc_cyc), W'(STAGES));
                        void'(q.pop_front());
                        consumed++;
                    end
                end
            end
            if (o_valid && !i_ready) stalls++;
            if (i_valid && o_ready)
                q.push_back(model(i_op1, i_op2, i_cin, i_sub, i_tag, cyc, stalls));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [TAG_W-1:0] tag);
        bit acc;
        acc     = 1'b0;
        i_valid = 1'b1;
        i_op1   = a;
        i_op2   = b;
        i_cin   = cin;
        i_sub   = sub;
        i_tag   = tag;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = o_ready;
            tick();
        end
        if (!acc) check("send_timeout", 0, 1);
        i_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [W-1:0] s, input logic c,
                               input logic [TAG_W-1:0] t);
        i_ready = 1'b1;
        for (int k = 0; k < 50 && !o_valid; k++) tick();
        check({name, "_valid"}, o_valid, 1'b1);
        check({name, "_sum"}, o_sum, s);
        check({name, "_cout"}, o_cout, c);
        check({name, "_tag"}, o_tag, t);
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        int  n_sent;
        int  hold;
        bit  first_seen;
        bit  acc;
        int  base;

        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_op1 = '0; i_op2 = '0; i_cin = 1'b0; i_sub = 1'b0; i_tag = '0;
        tick(); tick(); tick();
        check("rst_valid", o_valid, 1'b0);
        check("rst_sum", o_sum, '0);
        check("rst_cout", o_cout, 1'b0);
        check("rst_tag", o_tag, '0);
        rst = 1'b0;
        tick();
        check("rst_ready", o_ready, 1'b1);

        // Wrap-around add and exact unstalled latency.
        send('1, 64'h1, 1'b0, 1'b0, 4'd3);
        for (int i = 0; i < STAGES - 1; i++) begin
            check("lat_early", o_valid, 1'b0);
            tick();
        end
        wait_result("wrap_add", '0, 1'b1, 4'd3);
        tick();

        send(64'd5, 64'd7, 1'b0, 1'b1, 4'd1);
        wait_result("sub_5_7", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'd1);
        tick();
        send(64'd7, 64'd5, 1'b0, 1'b1, 4'd2);
        wait_result("sub_7_5", 64'd2, 1'b1, 4'd2);
        tick();

`ifdef RISCV_CORE_CLA_FLAGS_EN
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4'd5);
        wait_result("ovf_add", 64'h8000_0000_0000_0000, 1'b0, 4'd5);
        check("ovf_add_ovf", o_ovf, 1'b1);
        check("ovf_add_neg", o_neg, 1'b1);
        check("ovf_add_zero", o_zero, 1'b0);
        tick();
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 4'd6);
        wait_result("zero_sub", '0, 1'b1, 4'd6);
        check("zero_sub_zero", o_zero, 1'b1);
        check("zero_sub_ovf", o_ovf, 1'b0);
        tick();
`endif

        // Back-to-back stream with a three-cycle downstream hold.
        n_sent = 0; hold = 0; first_seen = 1'b0; base = consumed;
        for (int c = 0; c < 100 && (n_sent < 8 || q.size() != 0); c++) begin
            i_valid = (n_sent < 8);
            i_op1   = W'(n_sent);
            i_op2   = W'(n_sent);
            i_cin   = 1'b0;
            i_sub   = 1'b0;
            i_tag   = TAG_W'(n_sent);
            if (o_valid && !first_seen) begin
                first_seen = 1'b1;
                hold       = 3;
            end
            i_ready = (hold == 0);
            @(negedge clk);
            if (hold > 0) begin
                check("hold_valid", o_valid, 1'b1);
                check("hold_sum", o_sum, '0);
                check("hold_ready", o_ready, 1'b0);
            end
            acc = i_valid && o_ready;
            tick();
            if (acc) n_sent++;
            if (hold > 0) hold--;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("stream_count", W'(consumed - base), W'(8));

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; i_op1 = rand_word(); i_op2 = rand_word(); i_tag = TAG_W'(9 + i);
            tick();
        end
        rst = 1'b1;
        #1;
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_sum", o_sum, '0);
        i_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < STAGES + 2; i++) begin
            check("post_rst_valid", o_valid, 1'b0);
            tick();
        end

        // Random traffic with random backpressure, then unstalled random traffic.
        for (int c = 0; c < 6000; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = (c >= 4000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            i_op1   = rand_word();
            i_op2   = rand_word();
            i_cin   = 1'($urandom_range(0, 1));
            i_sub   = 1'($urandom_range(0, 1));
            i_tag   = TAG_W'($urandom);
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 3 * STAGES + 10; i++) tick();
        check("drain_queue", W'(q.size()), '0);
        check("drain_valid", o_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
